// File: rtl/fir_fix_decim_out.sv
// Decimating output stage for the fixed-point FIR: phase-selects one result in OSR,
// converts to signed, rounds/saturates to OUT_W and buffers it in a FWFT FIFO.
module fir_fix_decim_out #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int OSR        = 1,
  parameter int OFFSET_BIN = 1,
  parameter int FIFO_DEPTH = 8,
  parameter int PW         = (OSR > 1) ? $clog2(OSR) : 1,
  parameter int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic [PW-1:0]    phase,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic             sat,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int S  = IN_W - OUT_W;
  localparam int RS = (S > 0) ? S - 1 : 0;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PW-1:0]        CNT_MAX  = PW'(OSR - 1);
  localparam logic [LW-1:0]        FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [IN_W-1:0]      MSB_FLIP = (OFFSET_BIN != 0) ? {1'b1, {(IN_W-1){1'b0}}} : '0;
  localparam logic signed [IN_W:0] ONE      = {{IN_W{1'b0}}, 1'b1};
  localparam logic signed [IN_W:0] HALF     = (S > 0) ? (ONE <<< RS) : '0;
  localparam logic signed [IN_W:0] MAX_V    = {{(S+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V    = ~MAX_V;

  // Round half up toward +inf; one guard bit keeps x + HALF from wrapping.
  function automatic logic signed [IN_W:0] round_half_up(input logic signed [IN_W-1:0] x);
    logic signed [IN_W:0] xe;
    xe = {x[IN_W-1], x};
    return (xe + HALF) >>> S;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] y);
    if (y > MAX_V)
      return {1'b1, MAX_V[OUT_W-1:0]};
    else if (y < MIN_V)
      return {1'b1, MIN_V[OUT_W-1:0]};
    else
      return {1'b0, y[OUT_W-1:0]};
  endfunction

  logic [PW-1:0]          cnt;
  logic                   accept;
  logic signed [IN_W-1:0] conv;
  logic [OUT_W:0]         rs;
  logic [OUT_W-1:0]       data_p0;
  logic                   sat_p0;
  logic                   vld_p0;

  assign accept = in_valid && (cnt == phase);
  assign conv   = in_data ^ MSB_FLIP;
  assign rs     = saturate(round_half_up(conv));

  // Stage p0: phase-selected, converted sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      vld_p0 <= 1'b0;
    end else begin
      if (in_valid)
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      vld_p0 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0 <= rs[OUT_W-1:0];
      sat_p0  <= rs[OUT_W];
    end
  end

  // Stage p1: output FIFO (first-word-fall-through)
  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [OUT_W-1:0] last_data;
  logic             full;
  logic             rd_en;
  logic             wr_en;
  logic             drop;

  assign out_valid = (count != '0);
  assign full      = (count == FULL_LVL);
  assign rd_en     = out_valid && out_ready;
  // A full FIFO still takes a write when the head leaves on the same edge.
  assign wr_en     = vld_p0 && (!full || rd_en);
  assign drop      = vld_p0 && full && !rd_en;
  assign out_data  = out_valid ? mem[rd_ptr] : last_data;
  assign level     = count;
  assign sat       = wr_en && sat_p0;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= data_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_data <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_data <= mem[rd_ptr];
      end
      if (wr_en && !rd_en)
        count <= count + 1'b1;
      else if (rd_en && !wr_en)
        count <= count - 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

endmodule
